reg_window_ctrl: RTL and testbench
==================================

# reg_window_ctrl

Register-window manager for the single-cycle processor's windowed register file. Services core call/return requests by moving the current window pointer and, on window overflow or underflow, spilling or filling the private registers of a window to or from a stack in data memory over a req/ack handshake. While a transfer is in flight it drives the register file's window, register index and write port, and stalls the core.

## Interface
- STACK_BASE, 16'h0100, word address of the bottom of the spill stack
- MAX_SPILL, 64, maximum number of spilled windows before overflow error
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- call_req  in  1  single-cycle request: advance to next window
- ret_req  in  1  single-cycle request: return to previous window
- ready  out  1  high when idle and requests are accepted
- err  out  1  one-cycle pulse on illegal request
- cwp  out  2  current window pointer seen by the core
- rf_window  out  2  window presented to the register file: cwp when idle, target window when busy
- rf_reg  out  2  logical register index used during spill/fill
- rf_rd_data  in  16  combinational read data from the register file for rf_window/rf_reg
- rf_wr_en  out  1  register-file write strobe during fill
- rf_wr_data  out  16  fill write data
- mem_req, mem_we  out  1 each  memory request, write-enable
- mem_addr, mem_wdata  out  16 each  word address, write data
- mem_rdata  in  16  read data, valid with mem_ack
- mem_ack  in  1  transfer complete
- spill_cnt, fill_cnt  out  8 each  statistics (see Configuration)

## Operation
- Window model: 4 windows on 8 physical registers; window w logical r2,r3 alias window w+1 r0,r1. Private registers of a window are r0,r1.
- State: cwp (2b), resident (1..3), spilled (0..MAX_SPILL), sp (16b), FSM {IDLE, SPILL0, SPILL1, FILL0, FILL1, COMMIT}.
- Call, resident<3: cwp+1, resident+1, stays IDLE.
- Call, resident==3, spilled<MAX_SPILL: spill oldest window (cwp-2 mod 4): SPILL0 writes r0 to mem[sp], SPILL1 writes r1 to mem[sp+1]; COMMIT: sp+=2, spilled+1, cwp+1, resident unchanged.
- Call, resident==3, spilled==MAX_SPILL: err pulse, no state change.
- Return, resident>1: cwp-1, resident-1.
- Return, resident==1, spilled>0: fill window cwp-1: FILL0 reads mem[sp-2] into r0, FILL1 reads mem[sp-1] into r1; COMMIT: sp-=2, spilled-1, cwp-1.
- Return, resident==1, spilled==0: err pulse, no change.
- call_req and ret_req together: err pulse, both ignored. Requests with ready=0 ignored, no err.
- cwp, resident, sp wrap modulo their widths; sp never wraps when MAX_SPILL respected.

## Timing
- Reset (next edge): cwp=0, resident=1, spilled=0, sp=STACK_BASE, IDLE, ready=1, err=0, mem_req=0, rf_wr_en=0, counters=0. Reset mid-transfer abandons it; late mem_ack ignored.
- Non-spill call/return: cwp updates on the accepting edge; ready stays 1.
- Memory handshake: mem_req, mem_we, mem_addr, mem_wdata stable from state entry until the edge on which mem_ack=1; advance on that edge; mem_req may stay high into next transfer.
- Spill: mem_wdata = rf_rd_data combinationally, rf_window = cwp-2, rf_reg = 0/1 per state.
- Fill: rf_wr_en = mem_ack in FILL0/FILL1, rf_wr_data = mem_rdata, same cycle.
- Latency: spill/fill = 2 acked transfers + 1 COMMIT cycle; with zero-wait ack, ready low exactly 3 cycles, cwp changes at COMMIT edge.

## Configuration
- WIN_STATS_EN defined: spill_cnt/fill_cnt increment at each spill/fill COMMIT, saturate at 255, clear on rst.
- Undefined: spill_cnt, fill_cnt tied to 0; no counter logic.

## Test plan
- Reset then 2 calls -> cwp 0→1→2, ready stays 1, no mem_req.
- 3rd call with ack held high -> mem writes addr 0x0100 (window 0 r0), 0x0101 (r1), ready low 3 cycles, cwp=3, sp=0x0102.
- Then 3 returns -> last one fills: reads 0x0100/0x0101, rf_wr_en twice into window 0 r0/r1 with returned data, cwp=0, sp=0x0100.
- Return at reset state -> err pulse 1 cycle, cwp=0; call_req+ret_req together -> err, no change.
- Spill with mem_ack delayed 4 cycles -> mem_addr/mem_wdata stable for all wait cycles; rst asserted in SPILL1 -> IDLE, sp=0x0100, mem_req=0 next cycle.
- With WIN_STATS_EN: 2 spills + 1 fill -> spill_cnt=2, fill_cnt=1; without -> both 0.

Source files
------------

// File: rtl/reg_window_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_window_ctrl_if
// Purpose  : Bundles the core request, register-file and spill-stack memory
//            signals of the register-window manager.
//            master = window controller, slave = core/register file/memory.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_window_ctrl_if ();
  // core side
  logic        call_req;
  logic        ret_req;
  logic        ready;
  logic        err;
  logic [1:0]  cwp;
  // register-file side
  logic [1:0]  rf_window;
  logic [1:0]  rf_reg;
  logic [15:0] rf_rd_data;
  logic        rf_wr_en;
  logic [15:0] rf_wr_data;
  // spill-stack memory side
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  // statistics
  logic [7:0]  spill_cnt;
  logic [7:0]  fill_cnt;

  modport master (
    input  call_req, ret_req, rf_rd_data, mem_rdata, mem_ack,
    output ready, err, cwp, rf_window, rf_reg, rf_wr_en, rf_wr_data,
           mem_req, mem_we, mem_addr, mem_wdata, spill_cnt, fill_cnt
  );

  modport slave (
    output call_req, ret_req, rf_rd_data, mem_rdata, mem_ack,
    input  ready, err, cwp, rf_window, rf_reg, rf_wr_en, rf_wr_data,
           mem_req, mem_we, mem_addr, mem_wdata, spill_cnt, fill_cnt
  );
endinterface
`default_nettype wire

// File: rtl/reg_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reg_window_ctrl
// Purpose  : Register-window manager. Moves the current window pointer on
//            call/return and spills/fills the private registers (r0,r1) of a
//            window to/from a stack in data memory on overflow/underflow.
//            Optional macro WIN_STATS_EN enables saturating spill/fill
//            counters; without it the counters read as zero.
// Revision : 1.0 - initial release
// ============================================================================
module reg_window_ctrl #(
  parameter logic [15:0] STACK_BASE = 16'h0100,
  parameter int          MAX_SPILL  = 64
) (
  input  wire logic          clk,
  input  wire logic          rst,
  reg_window_ctrl_if.master  bus
);

  localparam int              c_SPW       = $clog2(MAX_SPILL + 1);
  localparam logic [c_SPW-1:0] c_MAX_SPILL = c_SPW'(MAX_SPILL);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SPILL0 = 3'd1,
    S_SPILL1 = 3'd2,
    S_FILL0  = 3'd3,
    S_FILL1  = 3'd4,
    S_COMMIT = 3'd5
  } state_t;

  state_t             r_state,    w_state_nxt;
  logic [1:0]         r_cwp,      w_cwp_nxt;
  logic [1:0]         r_resident, w_resident_nxt;
  logic [c_SPW-1:0]   r_spilled,  w_spilled_nxt;
  logic [15:0]        r_sp,       w_sp_nxt;
  logic               r_is_spill, w_is_spill_nxt;
  logic               r_err,      w_err_nxt;

  // Oldest resident window (spill victim) and the window being refilled.
  logic [1:0] w_spill_win;
  logic [1:0] w_fill_win;
  assign w_spill_win = r_cwp - 2'd2;
  assign w_fill_win  = r_cwp - 2'd1;

  // State register: all controller state advances together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cwp      <= 2'd0;
      r_resident <= 2'd1;
      r_spilled  <= '0;
      r_sp       <= STACK_BASE;
      r_is_spill <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cwp      <= w_cwp_nxt;
      r_resident <= w_resident_nxt;
      r_spilled  <= w_spilled_nxt;
      r_sp       <= w_sp_nxt;
      r_is_spill <= w_is_spill_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Next-state logic: request decode in IDLE, handshake sequencing otherwise.
  always_comb begin
    w_state_nxt    = r_state;
    w_cwp_nxt      = r_cwp;
    w_resident_nxt = r_resident;
    w_spilled_nxt  = r_spilled;
    w_sp_nxt       = r_sp;
    w_is_spill_nxt = r_is_spill;
    w_err_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.call_req && bus.ret_req) begin
          w_err_nxt = 1'b1;
        end else if (bus.call_req) begin
          if (r_resident < 2'd3) begin
            w_cwp_nxt      = r_cwp + 2'd1;
            w_resident_nxt = r_resident + 2'd1;
          end else if (r_spilled < c_MAX_SPILL) begin
            w_state_nxt    = S_SPILL0;
            w_is_spill_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (bus.ret_req) begin
          if (r_resident > 2'd1) begin
            w_cwp_nxt      = r_cwp - 2'd1;
            w_resident_nxt = r_resident - 2'd1;
          end else if (r_spilled != '0) begin
            w_state_nxt    = S_FILL0;
            w_is_spill_nxt = 1'b0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_SPILL0: if (bus.mem_ack) w_state_nxt = S_SPILL1;
      S_SPILL1: if (bus.mem_ack) w_state_nxt = S_COMMIT;
      S_FILL0:  if (bus.mem_ack) w_state_nxt = S_FILL1;
      S_FILL1:  if (bus.mem_ack) w_state_nxt = S_COMMIT;
      S_COMMIT: begin
        // Resident count is unchanged: a spill evicts one window while the
        // call adds one; a fill restores the window the return moves into.
        w_state_nxt = S_IDLE;
        if (r_is_spill) begin
          w_sp_nxt      = r_sp + 16'd2;
          w_spilled_nxt = r_spilled + 1'b1;
          w_cwp_nxt     = r_cwp + 2'd1;
        end else begin
          w_sp_nxt      = r_sp - 16'd2;
          w_spilled_nxt = r_spilled - 1'b1;
          w_cwp_nxt     = r_cwp - 2'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: register-file steering and memory request per state.
  always_comb begin
    bus.rf_window = r_cwp;
    bus.rf_reg    = 2'd0;
    bus.rf_wr_en  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = r_sp;
    bus.mem_wdata = 16'h0000;
    case (r_state)
      S_SPILL0: begin
        bus.rf_window = w_spill_win;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = r_sp;
        bus.mem_wdata = bus.rf_rd_data;
      end
      S_SPILL1: begin
        bus.rf_window = w_spill_win;
        bus.rf_reg    = 2'd1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = r_sp + 16'd1;
        bus.mem_wdata = bus.rf_rd_data;
      end
      S_FILL0: begin
        bus.rf_window = w_fill_win;
        bus.rf_wr_en  = bus.mem_ack;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = r_sp - 16'd2;
      end
      S_FILL1: begin
        bus.rf_window = w_fill_win;
        bus.rf_reg    = 2'd1;
        bus.rf_wr_en  = bus.mem_ack;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = r_sp - 16'd1;
      end
      S_COMMIT: begin
        bus.rf_window = r_is_spill ? w_spill_win : w_fill_win;
      end
      default: ;
    endcase
  end

  assign bus.rf_wr_data = bus.mem_rdata;
  assign bus.ready      = (r_state == S_IDLE);
  assign bus.err        = r_err;
  assign bus.cwp        = r_cwp;

`ifdef WIN_STATS_EN
  logic [7:0] r_spill_cnt;
  logic [7:0] r_fill_cnt;

  // Saturating statistics counters, bumped on each completed transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_spill_cnt <= 8'd0;
      r_fill_cnt  <= 8'd0;
    end else if (r_state == S_COMMIT) begin
      if (r_is_spill && r_spill_cnt != 8'hFF) r_spill_cnt <= r_spill_cnt + 8'd1;
      if (!r_is_spill && r_fill_cnt != 8'hFF) r_fill_cnt <= r_fill_cnt + 8'd1;
    end
  end

  assign bus.spill_cnt = r_spill_cnt;
  assign bus.fill_cnt  = r_fill_cnt;
`else
  assign bus.spill_cnt = 8'd0;
  assign bus.fill_cnt  = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_window_ctrl
// Purpose  : Scoreboard bench for reg_window_ctrl. A stack-based reference
//            model predicts every memory transfer; a negedge monitor checks
//            them as the DUT acknowledges them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_window_ctrl;

  localparam logic [15:0] c_BASE = 16'h0100;
  localparam int          c_MAX  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_window_ctrl_if bus ();

  reg_window_ctrl #(.STACK_BASE(c_BASE), .MAX_SPILL(c_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  win;
    logic [1:0]  rg;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // reference model state
  logic [1:0]  m_cwp;
  int          m_res;
  logic [15:0] m_stack[$];
  int          m_spills, m_fills;

  // environment models
  logic [15:0] rf [8] = '{default: 16'h0000};
  logic [15:0] mem [256];
  int          ack_mode = 0;   // 0 held high, 1 four wait cycles, 2 random
  int          wcnt = -1;
  logic        scr_req = 1'b0;
  int          scr_idx = 0;
  logic [15:0] scr_val = 16'h0;

  function automatic int ridx(logic [1:0] w, logic [1:0] r);
    return (int'(w) * 2 + int'(r)) % 8;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  assign bus.rf_rd_data = rf[ridx(bus.rf_window, bus.rf_reg)];
  assign bus.mem_rdata  = mem[bus.mem_addr[7:0]];

  // register file and memory storage updates
  always @(posedge clk) begin
    if (!rst && bus.rf_wr_en) rf[ridx(bus.rf_window, bus.rf_reg)] = bus.rf_wr_data;
    else if (scr_req) rf[scr_idx] = scr_val;
    if (!rst && bus.mem_req && bus.mem_we && bus.mem_ack) mem[bus.mem_addr[7:0]] = bus.mem_wdata;
  end

  // memory acknowledge generator
  always @(posedge clk) begin
    #1;
    if (ack_mode == 0) begin
      bus.mem_ack = 1'b1;
    end else if (!bus.mem_req) begin
      bus.mem_ack = 1'b0;
      wcnt = -1;
    end else begin
      if (wcnt < 0) wcnt = (ack_mode == 1) ? 4 : int'($urandom_range(0, 3));
      if (wcnt == 0) begin
        bus.mem_ack = 1'b1;
        wcnt = -1;
      end else begin
        bus.mem_ack = 1'b0;
        wcnt--;
      end
    end
  end

  // monitor: stability of the request and scoreboard compare on each ack
  logic        in_xfer = 1'b0;
  logic [15:0] lat_addr, lat_wdata;
  logic        lat_we;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rf_wr_en && !(bus.mem_req && bus.mem_ack && !bus.mem_we))
        chk("rf_wr_en_stray", 1, 0);
      if (bus.mem_req) begin
        if (!in_xfer) begin
          lat_addr = bus.mem_addr; lat_wdata = bus.mem_wdata; lat_we = bus.mem_we;
          in_xfer = 1'b1;
        end else begin
          chk("addr_stable", bus.mem_addr, lat_addr);
          chk("wdata_stable", bus.mem_wdata, lat_wdata);
          chk("we_stable", bus.mem_we, lat_we);
        end
        if (bus.mem_ack) begin
          if (q.size() == 0) begin
            chk("unexpected_xfer", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("mem_we", bus.mem_we, e.we);
            chk("mem_addr", bus.mem_addr, e.addr);
            if (e.we) begin
              chk("mem_wdata", bus.mem_wdata, e.data);
            end else begin
              chk("rf_wr_en", bus.rf_wr_en, 1);
              chk("fill_window", bus.rf_window, e.win);
              chk("fill_reg", bus.rf_reg, e.rg);
              chk("fill_data", bus.rf_wr_data, e.data);
            end
          end
          in_xfer = 1'b0;
        end
      end else begin
        in_xfer = 1'b0;
      end
    end
  end

  task automatic model_reset();
    m_cwp = 2'd0; m_res = 1; m_stack.delete(); m_spills = 0; m_fills = 0;
    q.delete();
  endtask

  task automatic scribble(input int i, input logic [15:0] v);
    scr_idx = i; scr_val = v; scr_req = 1'b1;
    @(posedge clk); #1;
    scr_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Predict the outcome of one request, drive it, and check the result.
  task automatic issue(input bit c, input bit r, input bit wait_done);
    bit          exp_err = 0, xfer = 0;
    logic [1:0]  w;
    logic [15:0] a;
    int          n, busy;
    if (c && r) exp_err = 1;
    else if (c) begin
      if (m_res < 3) begin m_cwp++; m_res++; end
      else if (m_stack.size() < 2 * c_MAX) begin
        w = m_cwp - 2'd2;
        a = c_BASE + 16'(m_stack.size());
        q.push_back('{1'b1, a,         rf[ridx(w, 2'd0)], w, 2'd0});
        q.push_back('{1'b1, a + 16'd1, rf[ridx(w, 2'd1)], w, 2'd1});
        m_stack.push_back(rf[ridx(w, 2'd0)]);
        m_stack.push_back(rf[ridx(w, 2'd1)]);
        m_cwp++; xfer = 1;
        if (m_spills < 255) m_spills++;
      end else exp_err = 1;
    end else if (r) begin
      if (m_res > 1) begin m_cwp--; m_res--; end
      else if (m_stack.size() > 0) begin
        w = m_cwp - 2'd1;
        n = m_stack.size();
        a = c_BASE + 16'(n);
        q.push_back('{1'b0, a - 16'd2, m_stack[n-2], w, 2'd0});
        q.push_back('{1'b0, a - 16'd1, m_stack[n-1], w, 2'd1});
        void'(m_stack.pop_back());
        void'(m_stack.pop_back());
        m_cwp--; xfer = 1;
        if (m_fills < 255) m_fills++;
      end else exp_err = 1;
    end
    bus.call_req = c; bus.ret_req = r;
    @(posedge clk); #1;
    bus.call_req = 1'b0; bus.ret_req = 1'b0;
    chk("err", bus.err, exp_err);
    if (!xfer) begin
      chk("ready_idle", bus.ready, 1);
      chk("no_mem_req", bus.mem_req, 0);
      chk("cwp", bus.cwp, m_cwp);
      if (exp_err) begin
        @(posedge clk); #1;
        chk("err_pulse_end", bus.err, 0);
      end
    end else if (wait_done) begin
      busy = 0;
      while (!bus.ready && busy < 200) begin
        busy++;
        @(posedge clk); #1;
      end
      if (busy >= 200) chk("ready_timeout", 0, 1);
      if (ack_mode == 0) chk("busy_cycles", busy, 3);
      chk("cwp_after_xfer", bus.cwp, m_cwp);
    end
  endtask

  task automatic chk_counters(input string name);
`ifdef WIN_STATS_EN
    chk({name, "_spill_cnt"}, bus.spill_cnt, m_spills);
    chk({name, "_fill_cnt"}, bus.fill_cnt, m_fills);
`else
    chk({name, "_spill_cnt"}, bus.spill_cnt, 0);
    chk({name, "_fill_cnt"}, bus.fill_cnt, 0);
`endif
  endtask

  initial begin
    bus.call_req = 1'b0;
    bus.ret_req  = 1'b0;
    bus.mem_ack  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", bus.ready, 1);
    chk("rst_cwp", bus.cwp, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_rf_wr_en", bus.rf_wr_en, 0);
    chk_counters("rst");

    for (int i = 0; i < 8; i++) scribble(i, 16'($urandom));

    // calls with zero-wait ack, third one spills window 0
    ack_mode = 0;
    issue(1, 0, 1); issue(1, 0, 1); issue(1, 0, 1);
    // returns, the last one fills window 0 back
    issue(0, 1, 1); issue(0, 1, 1); issue(0, 1, 1);
    chk("cwp_home", bus.cwp, 0);
    // illegal requests at the reset state
    issue(0, 1, 1);
    issue(1, 1, 1);

    // reset in the middle of a delayed spill
    ack_mode = 1;
    issue(1, 0, 1); issue(1, 0, 1);
    issue(1, 0, 0);
    begin
      int k;
      for (k = 0; k < 50; k++) begin
        if (bus.mem_req && bus.mem_we && bus.mem_addr == c_BASE + 16'd1) break;
        @(posedge clk); #1;
      end
      chk("reach_spill1", (k < 50), 1);
    end
    @(posedge clk); #1;
    do_reset();
    chk("mid_rst_ready", bus.ready, 1);
    chk("mid_rst_mem_req", bus.mem_req, 0);
    chk("mid_rst_cwp", bus.cwp, 0);

    // two spills and one fill, stack pointer must have restarted at base
    ack_mode = 0;
    for (int i = 0; i < 4; i++) issue(1, 0, 1);
    for (int i = 0; i < 3; i++) issue(0, 1, 1);
    chk_counters("stats");

    // fill the stack to its limit, overflow, then drain and underflow
    ack_mode = 2;
    while (!(m_res == 3 && m_stack.size() == 2 * c_MAX)) issue(1, 0, 1);
    issue(1, 0, 1);
    while (!(m_res == 1 && m_stack.size() == 0)) issue(0, 1, 1);
    issue(0, 1, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int sel;
      if ($urandom_range(0, 3) == 0) scribble(int'($urandom_range(0, 7)), 16'($urandom));
      sel = int'($urandom_range(0, 99));
      if (sel < 48)      issue(1, 0, 1);
      else if (sel < 93) issue(0, 1, 1);
      else               issue(1, 1, 1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    chk("final_cwp", bus.cwp, m_cwp);
    chk_counters("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // absolute time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
